// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_LSU_RD = 2'd2,
        ST_LSU_WR = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_RSVD = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    // Per-transaction payload latched on acceptance.
    typedef struct packed {
        logic [IDX_W-1:0]  last;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    // Index of the final byte; the reserved size code behaves as a word.
    function automatic logic [IDX_W-1:0] last_index(input logic [1:0] size);
        return (size == SZ_RSVD) ? IDX_W'(SZ_WORD) : size;
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_asm.sv
// Inserts one RAM byte into a partially assembled little-endian word.
module mem_arbiter_byte_asm
    import mem_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BYTE_W-1:0] din,
    output logic [DATA_W-1:0] merged_c
);

    always_comb begin
        merged_c = word;
        for (int unsigned b = 0; b < (DATA_W / BYTE_W); b++) begin
            if (idx == IDX_W'(b)) begin
                merged_c[b*BYTE_W +: BYTE_W] = din;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch and the LSU,
// sequencing multi-byte accesses little-endian and aborting fetches on a taken branch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned        ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              branch_or_not,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsu_req,
    input  logic              lsu_wr,
    input  logic [1:0]        lsu_size,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              busy
);

    state_e              state;
    txn_t                txn;
    logic [IDX_W-1:0]    idx;       // byte currently on mem_a
    logic [IDX_W-1:0]    cap_idx;   // byte arriving on mem_din this cycle
    logic                cap_vld;
    logic                tail;      // every byte has been addressed
    logic [DATA_W-1:0]   asm_word;
    logic                wr_q;

    logic [DATA_W-1:0]   merged_c;
    logic [ADDR_W-1:0]   next_a_c;
    logic [IDX_W-1:0]    next_idx_c;
    logic [BYTE_W-1:0]   next_byte_c;
    logic                stall_acc_c;
    logic                stall_cur_c;
    logic                stall_next_c;
    logic                just_done_c;

    mem_arbiter_byte_asm u_asm (
        .word     (asm_word),
        .idx      (cap_idx),
        .din      (mem_din),
        .merged_c (merged_c)
    );

    assign next_a_c     = mem_a + ADDR_W'(1);
    assign next_idx_c   = idx + IDX_W'(1);
    assign next_byte_c  = BYTE_W'(txn.wdata >> {next_idx_c, 3'b000});
    assign stall_acc_c  = io_buffer_full && (lsu_addr >= IO_BASE);
    assign stall_cur_c  = io_buffer_full && (mem_a >= IO_BASE);
    assign stall_next_c = io_buffer_full && (next_a_c >= IO_BASE);
    assign just_done_c  = if_done || lsu_done;

    // The RAM never sees a write while the core is frozen.
    assign mem_wr = wr_q && rdy_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            txn       <= '0;
            idx       <= '0;
            cap_idx   <= '0;
            cap_vld   <= 1'b0;
            tail      <= 1'b0;
            asm_word  <= '0;
            wr_q      <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            if_done   <= 1'b0;
            if_data   <= '0;
            lsu_done  <= 1'b0;
            lsu_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            lsu_done <= 1'b0;
            if (!rdy_in) begin
                // mem_din tracks the held address while frozen, so an in-flight byte
                // is re-addressed instead of being lost.
                if ((state == ST_IF_RD || state == ST_LSU_RD) && cap_vld && !tail) begin
                    mem_a   <= mem_a - ADDR_W'(1);
                    idx     <= cap_idx;
                    cap_vld <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (lsu_req && !just_done_c) begin
                            mem_a     <= lsu_addr;
                            txn.last  <= last_index(lsu_size);
                            txn.wdata <= lsu_wdata;
                            idx       <= '0;
                            cap_vld   <= 1'b0;
                            tail      <= 1'b0;
                            asm_word  <= '0;
                            busy      <= 1'b1;
                            if (lsu_wr) begin
                                state    <= ST_LSU_WR;
                                mem_dout <= lsu_wdata[7:0];
                                wr_q     <= !stall_acc_c;
                            end else begin
                                state <= ST_LSU_RD;
                            end
                        end else if (if_req && !branch_or_not && !just_done_c) begin
                            state     <= ST_IF_RD;
                            mem_a     <= if_addr;
                            txn.last  <= IDX_W'(SZ_WORD);
                            txn.wdata <= '0;
                            idx       <= '0;
                            cap_vld   <= 1'b0;
                            tail      <= 1'b0;
                            asm_word  <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    ST_IF_RD, ST_LSU_RD: begin
                        if (state == ST_IF_RD && branch_or_not) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            if (cap_vld) begin
                                asm_word <= merged_c;
                            end
                            if (!tail) begin
                                cap_vld <= 1'b1;
                                cap_idx <= idx;
                                if (idx == txn.last) begin
                                    tail <= 1'b1;
                                end else begin
                                    idx   <= next_idx_c;
                                    mem_a <= next_a_c;
                                end
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                if (state == ST_IF_RD) begin
                                    if_data <= merged_c;
                                    if_done <= 1'b1;
                                end else begin
                                    lsu_rdata <= merged_c;
                                    lsu_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_LSU_WR: begin
                        if (wr_q) begin
                            if (idx == txn.last) begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                wr_q     <= 1'b0;
                                lsu_done <= 1'b1;
                            end else begin
                                idx      <= next_idx_c;
                                mem_a    <= next_a_c;
                                mem_dout <= next_byte_c;
                                wr_q     <= !stall_next_c;
                            end
                        end else begin
                            wr_q <= !stall_cur_c;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        wr_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
